// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if -- start/operand/result bundle for the sequential
// signed multiplier/divider.
//   ctrl_MULT, ctrl_DIV         : one-cycle start pulses (requester -> unit)
//   data_operandA/B             : operands, sampled on the start edge
//   data_result, data_exception : registered result and exception flag
//   data_resultRDY              : one-cycle completion pulse
//   busy                        : unit is iterating
// modport slave is the unit side, modport master the requester side.
interface multdiv_sequencer_if;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer -- 32-bit signed multiply (radix-2 Booth) and signed
// divide (restoring, on magnitudes) sharing one 64-bit working register.
// One iteration per clock, 32 iterations, then a finishing edge that writes
// the result and enters the one-cycle DONE state.
//   clk : clock, all state on rising edge
//   clr : synchronous active-high clear
//   bus : multdiv_sequencer_if.slave (start pulses, operands, result, flags)
module multdiv_sequencer (
   input  logic                  clk,
   input  logic                  clr,
   multdiv_sequencer_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [63:0] work;
   logic        qm1;          // Booth's implicit bit to the right of the multiplier
   logic [31:0] opa, opb;
   logic [31:0] result_q;
   logic        exc_q;

   logic        start;
   logic        last;

   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   assign start = bus.ctrl_MULT | bus.ctrl_DIV;
   // cnt counts completed iterations; at 32 the next edge finishes.
   assign last  = (cnt == 6'd32);

   // ---------------- next state ----------------
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = bus.ctrl_MULT ? MULT : DIV;
      end else begin
         unique case (state)
            IDLE:      state_nxt = IDLE;
            MULT, DIV: if (last) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- Booth step ----------------
   // Accumulator is widened to 33 bits so a multiplicand of -2^31 cannot
   // overflow the partial sum before the arithmetic shift.
   logic [32:0] booth_sum;
   logic [63:0] booth_work;

   always_comb begin
      booth_sum = {work[63], work[63:32]};
      unique case ({work[0], qm1})
         2'b01:   booth_sum = {work[63], work[63:32]} + {opa[31], opa};
         2'b10:   booth_sum = {work[63], work[63:32]} - {opa[31], opa};
         default: booth_sum = {work[63], work[63:32]};
      endcase
      booth_work = {booth_sum, work[31:1]};
   end

   // ---------------- restoring divide step ----------------
   // work = {remainder, dividend/quotient}; shift left one, trial-subtract.
   logic [31:0] dvs_mag;
   logic [33:0] div_diff;
   logic [63:0] div_work;

   always_comb begin
      dvs_mag  = mag(opb);
      div_diff = {1'b0, work[63:31]} - {2'b00, dvs_mag};
      if (div_diff[33]) div_work = {work[62:0], 1'b0};
      else              div_work = {div_diff[31:0], work[30:0], 1'b1};
   end

   // ---------------- finishing values ----------------
   logic        mult_exc;
   logic [31:0] div_res;
   logic        div_exc;

   always_comb begin
      // Product fits in 32 bits only when bits 63..31 are a pure sign extension.
      mult_exc = ~((&work[63:31]) | ~(|work[63:31]));
      div_exc  = (opb == 32'd0);
      if (div_exc)                div_res = 32'd0;
      else if (opa[31] ^ opb[31]) div_res = ~work[31:0] + 32'd1;
      else                        div_res = work[31:0];
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         work     <= 64'd0;
         qm1      <= 1'b0;
         opa      <= 32'd0;
         opb      <= 32'd0;
         result_q <= 32'd0;
         exc_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            opa <= bus.data_operandA;
            opb <= bus.data_operandB;
            cnt <= 6'd0;
            qm1 <= 1'b0;
            if (bus.ctrl_MULT) work <= {32'd0, bus.data_operandB};
            else               work <= {32'd0, mag(bus.data_operandA)};
         end else begin
            unique case (state)
               MULT: begin
                  if (last) begin
                     result_q <= work[31:0];
                     exc_q    <= mult_exc;
                  end else begin
                     work <= booth_work;
                     qm1  <= work[0];
                     cnt  <= cnt + 6'd1;
                  end
               end
               DIV: begin
                  if (last) begin
                     result_q <= div_res;
                     exc_q    <= div_exc;
                  end else begin
                     work <= div_work;
                     cnt  <= cnt + 6'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = (state == DONE);
   assign bus.busy           = (state == MULT) || (state == DIV);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer -- directed and randomized checks of
// multdiv_sequencer against an arithmetic reference model.
module tb_multdiv_sequencer;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   multdiv_sequencer_if bus ();

   multdiv_sequencer dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint      cyc = 0;
   bit          chk_en = 0;
   bit          pend = 0;
   longint      due = 0;
   logic [31:0] exp_res;
   logic        exp_exc;
   logic [31:0] m_res = '0;
   logic        m_exc = 1'b0;
   logic        m_rdy = 1'b0;
   logic        m_busy = 1'b0;

   task automatic calc(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
      longint sa, sb, p, q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (is_mult) begin
         p   = sa * sb;
         res = p[31:0];
         exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         res = 32'd0;
         exc = 1'b1;
      end else begin
         q   = sa / sb;
         res = q[31:0];
         exc = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (clr) begin
         pend   = 0;
         m_res  = '0;
         m_exc  = 1'b0;
         m_rdy  = 1'b0;
         m_busy = 1'b0;
         chk_en = 1;
      end else if (chk_en) begin
         m_rdy = 1'b0;
         if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            calc(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB, exp_res, exp_exc);
            pend = 1;
            due  = cyc + 33;
         end else if (pend && cyc == due) begin
            m_rdy = 1'b1;
            m_res = exp_res;
            m_exc = exp_exc;
            pend  = 0;
         end
         m_busy = pend;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",      bus.busy,           m_busy);
         check("resultRDY", bus.data_resultRDY, m_rdy);
         check("result",    bus.data_result,    m_res);
         check("exception", bus.data_exception, m_exc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      #1;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clk);
      #1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
   endtask

   // lat = rising edges from the start edge to the one entering DONE
   task automatic wait_rdy(input int limit, output int lat);
      lat = -1;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clk);
         if (bus.data_resultRDY === 1'b1) begin
            lat = n - 1;
            break;
         end
      end
      if (lat < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL rdy_timeout: no data_resultRDY within %0d cycles", limit);
      end
   endtask

   task automatic run_dir(input string name, input bit m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
      int lat;
      start_op(m, !m, a, b);
      wait_rdy(60, lat);
      check({name, "_latency"}, lat, 33);
      check({name, "_result"},  bus.data_result, res);
      check({name, "_exc"},     bus.data_exception, exc);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 7)
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return $urandom % 1000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int lat, pulses, first;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      check("reset_result", bus.data_result, 32'd0);
      check("reset_exc",    bus.data_exception, 1'b0);
      check("reset_rdy",    bus.data_resultRDY, 1'b0);
      check("reset_busy",   bus.busy, 1'b0);

      run_dir("mul_7xm3",     1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_dir("mul_ovf",      1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
      run_dir("mul_min_min",  1, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1);
      run_dir("mul_min_one",  1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
      run_dir("div_m7_2",     0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
      run_dir("div_by_zero",  0, 32'd7,          32'd0,         32'd0,         1'b1);
      run_dir("div_min_m1",   0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      run_dir("div_min_1",    0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);

      // New start issued during the DONE cycle of the previous op.
      start_op(1, 0, 32'd3, 32'd4);
      wait_rdy(60, lat);
      check("b2b_first_result", bus.data_result, 32'd12);
      start_op(0, 1, 32'd100, 32'd7);
      wait_rdy(60, lat);
      check("b2b_second_latency", lat, 33);
      check("b2b_second_result",  bus.data_result, 32'd14);

      // Multiply aborted by a divide 10 cycles in: only the divide completes.
      start_op(1, 0, 32'd5, 32'd5);
      repeat (10) @(negedge clk);
      start_op(0, 1, 32'd100, 32'd7);
      pulses = 0;
      first  = -1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (bus.data_resultRDY === 1'b1) begin
            pulses++;
            if (first < 0) first = n - 1;
         end
      end
      check("abort_pulses",  pulses, 1);
      check("abort_latency", first, 33);
      check("abort_result",  bus.data_result, 32'd14);

      // clr on cycle 20 of a multiply, with ctrl_DIV high on the same edge.
      start_op(1, 0, 32'd9, 32'd9);
      repeat (19) @(posedge clk);
      #1;
      clr          = 1'b1;
      bus.ctrl_DIV = 1'b1;
      @(posedge clk);
      #1;
      clr          = 1'b0;
      bus.ctrl_DIV = 1'b0;
      @(negedge clk);
      check("clr_result", bus.data_result, 32'd0);
      check("clr_exc",    bus.data_exception, 1'b0);
      check("clr_busy",   bus.busy, 1'b0);
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.data_resultRDY === 1'b1) pulses++;
      end
      check("clr_no_pulse", pulses, 0);

      // Randomized traffic: mixed ops, aborts, both-high starts, clr pulses.
      for (int i = 0; i < 300; i++) begin
         bit m, d;
         int gap;
         m = $urandom % 2;
         d = !m || (($urandom % 8) == 0);
         start_op(m, d, pick(), pick());
         gap = $urandom_range(0, 45);
         repeat (gap) @(negedge clk);
         if (($urandom % 20) == 0) begin
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
         end
      end
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
